// File: rtl/delay_seq_pkg.sv
// Shared types and constants for the IDELAYE3 VAR_LOAD tap sequencer.
package delay_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_RDY,
    IDLE,
    VTC_OFF,
    LOAD,
    SETTLE,
    VERIFY,
    VTC_ON
  } seq_state_t;

  localparam int unsigned IDELAY_CNT_W = 9;

endpackage

// File: rtl/lowest_set_idx.sv
// Combinational find-first-set: index of the lowest set bit and a valid flag.
module lowest_set_idx #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]                         vec,
  output logic [((W > 1) ? $clog2(W) : 1)-1:0] idx,
  output logic                                 valid
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  // Scan downwards so the last hit, i.e. the lowest index, wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = W; i > 0; i--) begin
      if (vec[i-1]) begin
        idx   = IW'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_delay_load_seq.sv
// N-channel IDELAYE3 VAR_LOAD sequencer: VTC off, LOAD pulse, settle, verify, VTC on,
// one channel at a time, lowest dirty index first.
module multi_delay_load_seq
  import delay_seq_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned CNT_W     = IDELAY_CNT_W,
  parameter int unsigned WAIT_CYC  = 10,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned VERIFY_EN = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           rdy,
  input  logic                                           cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                               cfg_value,
  input  logic [NUM_CH*CNT_W-1:0]                        cntvalueout,
  output logic [NUM_CH-1:0]                              en_vtc,
  output logic [NUM_CH-1:0]                              load,
  output logic [NUM_CH*CNT_W-1:0]                        cntvaluein,
  output logic [NUM_CH-1:0]                              done,
  output logic [NUM_CH-1:0]                              err,
  output logic                                           busy
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WCNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_t                state_q, state_d;
  logic [CH_W-1:0]           cur_q, cur_d;
  logic [WCNT_W-1:0]         cnt_q, cnt_d;
  logic [RTY_W-1:0]          retry_q, retry_d;
  logic [CNT_W-1:0]          snap_q, snap_d;
  logic [NUM_CH*CNT_W-1:0]   target_q, target_d;
  logic [NUM_CH-1:0]         dirty_q, dirty_d;
  logic [NUM_CH-1:0]         done_q, done_d;
  logic [NUM_CH-1:0]         err_q, err_d;
  logic [NUM_CH-1:0]         en_vtc_q, en_vtc_d;
  logic [NUM_CH-1:0]         load_q, load_d;
  logic                      busy_q, busy_d;
  logic [CH_W-1:0]           pick_idx;
  logic                      pick_vld;

  lowest_set_idx #(.W(NUM_CH)) u_pick (
    .vec   (dirty_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    snap_d   = snap_q;
    target_d = target_q;
    dirty_d  = dirty_q;
    done_d   = done_q;
    err_d    = err_q;
    en_vtc_d = en_vtc_q;
    load_d   = '0;

    if (state_q != WAIT_RDY && !rdy) begin
      state_d  = WAIT_RDY;
      en_vtc_d = '1;
      retry_d  = '0;
      if (busy_q) dirty_d[cur_q] = 1'b1;
    end else begin
      case (state_q)
        WAIT_RDY: begin
          en_vtc_d = '1;
          if (rdy) begin
            state_d = IDLE;
            done_d  = ~dirty_q;
          end
        end
        IDLE: begin
          if (pick_vld) begin
            cur_d             = pick_idx;
            dirty_d[pick_idx] = 1'b0;
            cnt_d             = WCNT_W'(WAIT_CYC);
            state_d           = VTC_OFF;
          end
        end
        VTC_OFF: begin
          en_vtc_d[cur_q] = 1'b0;
          // LOAD is issued on the way into the LOAD state so it coincides with it.
          if (cnt_q == '0) begin
            state_d       = LOAD;
            load_d[cur_q] = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        LOAD: begin
          snap_d  = target_q[cur_q*CNT_W +: CNT_W];
          cnt_d   = WCNT_W'(WAIT_CYC);
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            if (VERIFY_EN != 0) begin
              state_d = VERIFY;
            end else begin
              state_d         = VTC_ON;
              en_vtc_d[cur_q] = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        VERIFY: begin
          if (cntvalueout[cur_q*CNT_W +: CNT_W] == snap_q) begin
            state_d         = VTC_ON;
            en_vtc_d[cur_q] = 1'b1;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            cnt_d   = WCNT_W'(WAIT_CYC);
            state_d = VTC_OFF;
          end else begin
            err_d[cur_q]    = 1'b1;
            state_d         = VTC_ON;
            en_vtc_d[cur_q] = 1'b1;
          end
        end
        VTC_ON: begin
          en_vtc_d[cur_q] = 1'b1;
          retry_d         = '0;
          done_d[cur_q]   = !err_q[cur_q] && !dirty_q[cur_q];
          state_d         = IDLE;
        end
        default: state_d = WAIT_RDY;
      endcase
    end

    // Applied last so a write beats IDLE clearing the same channel's dirty bit.
    if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
      target_d[cfg_ch*CNT_W +: CNT_W] = cfg_value;
      dirty_d[cfg_ch]                 = 1'b1;
      done_d[cfg_ch]                  = 1'b0;
      err_d[cfg_ch]                   = 1'b0;
    end

    busy_d = !(state_d == IDLE || state_d == WAIT_RDY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_RDY;
      cur_q    <= '0;
      cnt_q    <= '0;
      retry_q  <= '0;
      snap_q   <= '0;
      target_q <= '0;
      dirty_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      en_vtc_q <= '1;
      load_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      snap_q   <= snap_d;
      target_q <= target_d;
      dirty_q  <= dirty_d;
      done_q   <= done_d;
      err_q    <= err_d;
      en_vtc_q <= en_vtc_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
    end
  end

  assign en_vtc     = en_vtc_q;
  assign load       = load_q;
  assign cntvaluein = target_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule
